// File: rtl/recip_iter.sv
// recip_iter: iterative fixed-point reciprocal f = 1/a.
// One restoring-divide datapath resolves BITS_PER_CYCLE quotient bits per
// clock; the sign is applied and saturation checked after the last step.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous, active-high
//   in_valid   operand valid          in_ready   block can accept an operand
//   a          operand (WIDTH bits, SCALE fractional)
//   out_valid  result valid           out_ready  consumer accepts result
//   f          result (same Q-format as a)
//   ovf        result saturated, |1/a| not representable
//   dz         operand was zero
module recip_iter #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned SCALE          = 8,
  parameter int unsigned SIGNED         = 1,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf,
  output logic             dz
);

  // Quotient width, CALC cycle count and surplus steps in the last cycle.
  localparam int unsigned QB       = 2 * SCALE + 1;
  localparam int unsigned NCYC     = (QB + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned SURPLUS  = NCYC * BITS_PER_CYCLE - QB;
  localparam int unsigned FIRST_SP = BITS_PER_CYCLE - SURPLUS;
  localparam int unsigned CNT_W    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned CW       = (QB > WIDTH + 1) ? QB : WIDTH + 1;
  localparam bit          IS_SIGNED = (SIGNED != 0);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NCYC - 1);
  localparam logic [CW-1:0]    POS_LIM  = IS_SIGNED ? ((CW'(1) << (WIDTH - 1)) - CW'(1))
                                                    : ((CW'(1) << WIDTH) - CW'(1));
  localparam logic [CW-1:0]    NEG_LIM  = CW'(1) << (WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] m_q,         m_d;
  logic             neg_q,       neg_d;
  logic [WIDTH:0]   rem_q,       rem_d;
  logic [QB-1:0]    quo_q,       quo_d;
  logic [WIDTH-1:0] f_q,         f_d;
  logic             ovf_q,       ovf_d;
  logic             dz_q,        dz_d;
  logic             out_valid_q, out_valid_d;

  logic             neg_c;
  logic [WIDTH-1:0] mag_c;
  logic [WIDTH:0]   rem_t, rem_sh;
  logic [QB-1:0]    quo_t;
  logic [CW-1:0]    q_ext;
  logic             din;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // Operand magnitude; the most-negative input maps to 2^(WIDTH-1).
  always_comb begin
    neg_c = IS_SIGNED && a[WIDTH-1];
    mag_c = neg_c ? (~a + WIDTH'(1)) : a;
  end

  // Restoring-divide steps for one CALC cycle. The dividend 2^(2*SCALE) has
  // a single 1 in its MSB, fed on the very first step; surplus steps of the
  // final cycle are skipped so the quotient is not shifted past QB bits.
  always_comb begin
    rem_t  = rem_q;
    quo_t  = quo_q;
    rem_sh = '0;
    din    = 1'b0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (!((cnt_q == '0) && (j >= FIRST_SP))) begin
        din    = (cnt_q == CNT_LOAD) && (j == 0);
        rem_sh = {rem_t[WIDTH-1:0], din};
        if (rem_sh >= {1'b0, m_q}) begin
          rem_t = rem_sh - {1'b0, m_q};
          quo_t = {quo_t[QB-2:0], 1'b1};
        end else begin
          rem_t = rem_sh;
          quo_t = {quo_t[QB-2:0], 1'b0};
        end
      end
    end
    q_ext = CW'(quo_t);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_d         = m_q;
    neg_d       = neg_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    f_d         = f_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d   = mag_c;
          neg_d = neg_c;
          rem_d = '0;
          quo_d = '0;
          if (mag_c == '0) begin
            state_d     = S_DONE;
            f_d         = POS_LIM[WIDTH-1:0];
            ovf_d       = 1'b0;
            dz_d        = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_t;
        quo_d = quo_t;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          dz_d        = 1'b0;
          if (neg_q) begin
            ovf_d = (q_ext > NEG_LIM);
            f_d   = (q_ext > NEG_LIM) ? NEG_LIM[WIDTH-1:0] : WIDTH'(-q_ext);
          end else begin
            ovf_d = (q_ext > POS_LIM);
            f_d   = (q_ext > POS_LIM) ? POS_LIM[WIDTH-1:0] : WIDTH'(q_ext);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      m_q         <= '0;
      neg_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      f_q         <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_q         <= m_d;
      neg_q       <= neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      f_q         <= f_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_recip_iter.sv
// tb_recip_iter: self-checking bench for recip_iter at W16/S8.
// Instances: 0 signed BPC=1, 1 signed BPC=4, 2 signed BPC=17, 3 unsigned BPC=1.
module tb_recip_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [15:0] a         [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [15:0] f         [4];
  logic        ovf       [4];
  logic        dz        [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  recip_iter #(.WIDTH(16), .SCALE(8), .SIGNED(1), .BITS_PER_CYCLE(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .f(f[0]), .ovf(ovf[0]), .dz(dz[0]));
  recip_iter #(.WIDTH(16), .SCALE(8), .SIGNED(1), .BITS_PER_CYCLE(4)) u_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .f(f[1]), .ovf(ovf[1]), .dz(dz[1]));
  recip_iter #(.WIDTH(16), .SCALE(8), .SIGNED(1), .BITS_PER_CYCLE(17)) u_s17 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .f(f[2]), .ovf(ovf[2]), .dz(dz[2]));
  recip_iter #(.WIDTH(16), .SCALE(8), .SIGNED(0), .BITS_PER_CYCLE(1)) u_u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .a(a[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .f(f[3]), .ovf(ovf[3]), .dz(dz[3]));

  // Reference: {f, ovf, dz} from plain integer division 2^16 / |a|.
  function automatic logic [17:0] model(input logic [15:0] av, input bit sgn);
    longint mag, q, lim;
    bit     neg;
    neg = sgn && av[15];
    mag = neg ? (longint'(65536) - longint'(av)) : longint'(av);
    lim = sgn ? 32767 : 65535;
    if (mag == 0) return {16'(lim), 2'b01};
    q = longint'(65536) / mag;
    if (!neg) begin
      if (q > lim) return {16'(lim), 2'b10};
      return {16'(q), 2'b00};
    end
    if (q > 32768) return {16'h8000, 2'b10};
    return {16'(longint'(65536) - q), 2'b00};
  endfunction

  function automatic int bpc_of(input int k);
    return (k == 1) ? 4 : (k == 2) ? 17 : 1;
  endfunction

  // Cycles from accept to first out_valid.
  function automatic int exp_lat(input logic [15:0] av, input int k);
    if (av == 16'h0000) return 1;
    return (17 + bpc_of(k) - 1) / bpc_of(k) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k, output int cyc);
    cyc = 1;
    while (!out_valid[k] && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  // One transaction: accept, check latency/result, hold for 'hold' cycles, release.
  task automatic run_op(input int k, input logic [15:0] av, input int hold);
    logic [17:0] exp_r;
    logic [15:0] held;
    int          cyc;
    exp_r = model(av, k != 3);
    n_cmp++;
    if (in_ready[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_idle k=%0d got=%b exp=1", k, in_ready[k]);
    end
    in_valid[k] = 1'b1; a[k] = av; out_ready[k] = 1'b0;
    tick();
    in_valid[k] = 1'b0; a[k] = 16'($urandom);
    wait_valid(k, cyc);
    n_cmp++;
    if (cyc != exp_lat(av, k)) begin
      n_bad++;
      $display("FAIL latency k=%0d a=%h got=%0d exp=%0d", k, av, cyc, exp_lat(av, k));
    end
    n_cmp++;
    if ({f[k], ovf[k], dz[k]} !== exp_r) begin
      n_bad++;
      $display("FAIL result k=%0d a=%h got f=%h ovf=%b dz=%b exp f=%h ovf=%b dz=%b",
               k, av, f[k], ovf[k], dz[k], exp_r[17:2], exp_r[1], exp_r[0]);
    end
    held = f[k];
    for (int i = 0; i < hold; i++) begin
      tick();
      n_cmp++;
      if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || f[k] !== held) begin
        n_bad++;
        $display("FAIL hold k=%0d got v=%b r=%b f=%h exp v=1 r=0 f=%h",
                 k, out_valid[k], in_ready[k], f[k], held);
      end
    end
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    n_cmp++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL release k=%0d got v=%b r=%b exp v=0 r=1", k, out_valid[k], in_ready[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({out_valid[k], f[k], ovf[k], dz[k]} !== 19'd0) begin
        n_bad++;
        $display("FAIL reset_state k=%0d got v=%b f=%h ovf=%b dz=%b exp all 0",
                 k, out_valid[k], f[k], ovf[k], dz[k]);
      end
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (in_ready[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ready k=%0d got=%b exp=1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] vals [7];
    vals = '{16'h0100, 16'h0300, 16'hFF80, 16'h0001, 16'hFFFF, 16'h8000, 16'h0000};
    for (int k = 0; k < 3; k++)
      foreach (vals[i]) run_op(k, vals[i], 0);
    run_op(3, 16'h0000, 0);
    run_op(3, 16'h0100, 0);
    run_op(3, 16'h0001, 0);
    run_op(3, 16'hFF80, 0);
  endtask

  // Result must hold under backpressure; the waiting operand is taken only after.
  task automatic test_backpressure();
    logic [17:0] exp_r;
    int          cyc;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b1; a[k] = 16'h0300; out_ready[k] = 1'b0;
      tick();
      in_valid[k] = 1'b0;
      wait_valid(k, cyc);
      exp_r = model(16'h0300, 1'b1);
      in_valid[k] = 1'b1; a[k] = 16'h0500;
      for (int i = 0; i < 5; i++) begin
        tick();
        n_cmp++;
        if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || {f[k], ovf[k], dz[k]} !== exp_r) begin
          n_bad++;
          $display("FAIL bp_hold k=%0d got v=%b r=%b f=%h exp v=1 r=0 f=%h",
                   k, out_valid[k], in_ready[k], f[k], exp_r[17:2]);
        end
      end
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      n_cmp++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_release k=%0d got v=%b r=%b exp v=0 r=1", k, out_valid[k], in_ready[k]);
      end
      tick();
      in_valid[k] = 1'b0;
      wait_valid(k, cyc);
      exp_r = model(16'h0500, 1'b1);
      n_cmp++;
      if (cyc != exp_lat(16'h0500, k) || {f[k], ovf[k], dz[k]} !== exp_r) begin
        n_bad++;
        $display("FAIL bp_second k=%0d got lat=%0d f=%h exp lat=%0d f=%h",
                 k, cyc, f[k], exp_lat(16'h0500, k), exp_r[17:2]);
      end
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
    end
  endtask

  // Reset in CALC (instance 0) and in DONE (instance 1) discards both results.
  task automatic test_reset_mid();
    int seen;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b1; a[k] = 16'h0300; out_ready[k] = 1'b0;
    end
    tick();
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL mid_reset k=%0d got v=%b r=%b exp v=0 r=1", k, out_valid[k], in_ready[k]);
      end
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid[0] || out_valid[1]) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL mid_discard got=%0d valid cycles exp=0", seen);
    end
    run_op(0, 16'h0200, 0);
    run_op(1, 16'h0200, 0);
  endtask

  // out_ready tied high and in_valid held: one result every N+2 cycles.
  task automatic test_back_to_back(input int k);
    logic [15:0] pend [$];
    logic [15:0] av;
    logic [17:0] exp_r;
    int          last, got, period;
    last = -1; got = 0;
    period = exp_lat(16'h0001, k) + 1;
    out_ready[k] = 1'b1; in_valid[k] = 1'b1; a[k] = 16'($urandom_range(1, 65535));
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (in_ready[k]) pend.push_back(a[k]);
      tick();
      a[k] = 16'($urandom_range(1, 65535));
      if (out_valid[k]) begin
        av    = (pend.size() > 0) ? pend.pop_front() : 16'h0000;
        exp_r = model(av, k != 3);
        n_cmp++;
        if ({f[k], ovf[k], dz[k]} !== exp_r) begin
          n_bad++;
          $display("FAIL b2b_result k=%0d a=%h got f=%h exp f=%h", k, av, f[k], exp_r[17:2]);
        end
        if (last >= 0) begin
          n_cmp++;
          if (c - last != period) begin
            n_bad++;
            $display("FAIL b2b_period k=%0d got=%0d exp=%0d", k, c - last, period);
          end
        end
        last = c;
        got++;
      end
    end
    n_cmp++;
    if (got != 6) begin
      n_bad++;
      $display("FAIL b2b_count k=%0d got=%0d exp=6", k, got);
    end
    in_valid[k] = 1'b0;
    for (int i = 0; i < 30 && !in_ready[k]; i++) tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] av;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 20; n++) begin
        case ($urandom_range(0, 3))
          0:       av = 16'($urandom_range(0, 4));
          1:       av = 16'hFFFF - 16'($urandom_range(0, 4));
          default: av = 16'($urandom);
        endcase
        run_op(k, av, $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; a[k] = 16'h0000; out_ready[k] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
